cmp_stream_tracker: RTL

Sequential consumer of the 4-bit magnitude comparator. It accepts a valid/ready stream of 4-bit samples framed by start/last. Each new sample is compared against the previous sample, the running maximum and the running minimum, using three comparator_4bit instances. Per sequence, it reports rise/fall/equal transition counts, the sample count, and the max/min values, and then raises a done flag for the downstream reader.

---
 rtl/cmp_stream_tracker_if.sv | 11 +
 rtl/cmp_stream_tracker.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cmp_stream_tracker_if.sv
// Sample stream handshake for cmp_stream_tracker: the producer drives valid/data/last
// and the tracker drives ready.
interface cmp_stream_tracker_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/cmp_stream_tracker.sv
// Per-sequence statistics over a framed 4-bit sample stream: transition counts,
// sample count and running max/min, built on three 4-bit magnitude comparators.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

module cmp_stream_tracker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    cmp_stream_tracker_if.slave  in_if,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     rise_cnt,
    output logic [CNT_W-1:0]     fall_cnt,
    output logic [CNT_W-1:0]     eq_cnt,
    output logic [3:0]           max_val,
    output logic [3:0]           min_val
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [3:0]       max_q, max_d;
    logic [3:0]       min_q, min_d;
    logic [3:0]       prev_q, prev_d;
    logic             first_q, first_d;

    logic accept, start_go;
    logic prev_gt, prev_lt, prev_eq;
    logic max_gt, max_lt, max_eq;
    logic min_gt, min_lt, min_eq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + CNT_W'(1);
    endfunction

    comparator_4bit u_cmp_prev (.a(in_if.in_data), .b(prev_q), .gt(prev_gt), .lt(prev_lt), .eq(prev_eq));
    comparator_4bit u_cmp_max  (.a(in_if.in_data), .b(max_q),  .gt(max_gt),  .lt(max_lt),  .eq(max_eq));
    comparator_4bit u_cmp_min  (.a(in_if.in_data), .b(min_q),  .gt(min_gt),  .lt(min_lt),  .eq(min_eq));

    assign accept   = in_if.in_valid && (state_q == RUN);
    assign start_go = start && (state_q != RUN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an accepted last sample takes precedence because start is ignored in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && in_if.in_last) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end
    assign in_if.in_ready = (state_q == RUN);

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        rise_cnt_d   = rise_cnt_q;
        fall_cnt_d   = fall_cnt_q;
        eq_cnt_d     = eq_cnt_q;
        max_d        = max_q;
        min_d        = min_q;
        prev_d       = prev_q;
        first_d      = first_q;
        if (start_go) begin
            sample_cnt_d = '0;
            rise_cnt_d   = '0;
            fall_cnt_d   = '0;
            eq_cnt_d     = '0;
            max_d        = '0;
            min_d        = '0;
            first_d      = 1'b1;
        end else if (accept) begin
            sample_cnt_d = sat_inc(sample_cnt_q);
            prev_d       = in_if.in_data;
            first_d      = 1'b0;
            if (first_q) begin
                max_d = in_if.in_data;
                min_d = in_if.in_data;
            end else begin
                if (prev_gt) rise_cnt_d = sat_inc(rise_cnt_q);
                if (prev_lt) fall_cnt_d = sat_inc(fall_cnt_q);
                if (prev_eq) eq_cnt_d   = sat_inc(eq_cnt_q);
                if (max_gt)  max_d      = in_if.in_data;
                if (min_lt)  min_d      = in_if.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
            rise_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            eq_cnt_q     <= '0;
            max_q        <= '0;
            min_q        <= '0;
            prev_q       <= '0;
            first_q      <= 1'b1;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            rise_cnt_q   <= rise_cnt_d;
            fall_cnt_q   <= fall_cnt_d;
            eq_cnt_q     <= eq_cnt_d;
            max_q        <= max_d;
            min_q        <= min_d;
            prev_q       <= prev_d;
            first_q      <= first_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign rise_cnt   = rise_cnt_q;
    assign fall_cnt   = fall_cnt_q;
    assign eq_cnt     = eq_cnt_q;
    assign max_val    = max_q;
    assign min_val    = min_q;
endmodule
